// File: rtl/pc_ctrl_pkg.sv
// PC sequencer shared types: FSM state codes, PC mux selects
// and the one-hot RUN action bundle.
package pc_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_RST_RD   = 3'd0;
  localparam state_t ST_RST_LD   = 3'd1;
  localparam state_t ST_RUN      = 3'd2;
  localparam state_t ST_INT_PUSH = 3'd3;
  localparam state_t ST_INT_RD   = 3'd4;
  localparam state_t ST_INT_LD   = 3'd5;

  localparam logic [1:0] PC_SRC_EX  = 2'b00;
  localparam logic [1:0] PC_SRC_VEC = 2'b01;
  localparam logic [1:0] PC_SRC_D   = 2'b10;
  localparam logic [1:0] PC_SRC_STK = 2'b11;

  typedef struct packed {
    logic ret;
    logic jmp;
    logic br;
    logic hold;
    logic intr;
    logic inc;
  } act_t;

endpackage

// File: rtl/pc_seq_ctrl_prio.sv
// RUN-state redirect arbiter: oldest stage wins, exactly one
// action bit is set every cycle.
module pc_redirect_prio
  import pc_ctrl_pkg::*;
(
  input  logic ret,
  input  logic jmp,
  input  logic br,
  input  logic stall,
  input  logic intr,
  input  logic in_isr,
  output act_t act
);

  always_comb begin
    act = '0;
    if (ret)
      act.ret = 1'b1;
    else if (jmp)
      act.jmp = 1'b1;
    // a stalled branch reads a stale R[rb]; it is resampled later
    else if (stall)
      act.hold = 1'b1;
    else if (br)
      act.br = 1'b1;
    else if (intr && !in_isr)
      act.intr = 1'b1;
    else
      act.inc = 1'b1;
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencer: reset/interrupt vector fetch, redirect
// arbitration and pipeline flush control for the 8-bit PC.
module pc_seq_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              PC_W           = 8,
  parameter logic [PC_W-1:0] RESET_VEC_ADDR = '0,
  parameter logic [PC_W-1:0] INT_VEC_ADDR   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            intr,
  input  logic            br_taken_d,
  input  logic            jmp_ex,
  input  logic            ret_mem,
  input  logic            rti_mem,
  input  logic            hazard_stall,
  output logic [1:0]      pc_src,
  output logic            pc_load,
  output logic            pc_inc,
  output logic            vec_rd,
  output logic [PC_W-1:0] vec_addr,
  output logic            flush_fd,
  output logic            flush_de,
  output logic            flush_em,
  output logic            push_pc,
  output logic            int_ack,
  output logic            in_isr
);

  state_t state_q;
  state_t state_d;
  logic   in_isr_q;
  logic   isr_set;
  logic   isr_clr;
  act_t   act;

  pc_redirect_prio u_prio (
    .ret    (ret_mem),
    .jmp    (jmp_ex),
    .br     (br_taken_d),
    .stall  (hazard_stall),
    .intr   (intr),
    .in_isr (in_isr_q),
    .act    (act)
  );

  always_comb begin
    state_d  = state_q;
    pc_src   = PC_SRC_EX;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    vec_rd   = 1'b0;
    vec_addr = '0;
    flush_fd = 1'b0;
    flush_de = 1'b0;
    flush_em = 1'b0;
    push_pc  = 1'b0;
    int_ack  = 1'b0;
    isr_set  = 1'b0;
    isr_clr  = 1'b0;
    if (rst) begin
      state_d = ST_RST_RD;
    end else begin
      case (state_q)
        ST_RST_RD: begin
          vec_rd   = 1'b1;
          vec_addr = RESET_VEC_ADDR;
          state_d  = ST_RST_LD;
        end
        ST_RST_LD: begin
          vec_rd   = 1'b1;
          vec_addr = RESET_VEC_ADDR;
          pc_src   = PC_SRC_VEC;
          pc_load  = 1'b1;
          state_d  = ST_RUN;
        end
        ST_RUN: begin
          unique case (1'b1)
            act.ret: begin
              pc_src   = PC_SRC_STK;
              pc_load  = 1'b1;
              flush_fd = 1'b1;
              flush_de = 1'b1;
              flush_em = 1'b1;
              isr_clr  = rti_mem;
            end
            act.jmp: begin
              pc_src   = PC_SRC_EX;
              pc_load  = 1'b1;
              flush_fd = 1'b1;
              flush_de = 1'b1;
            end
            act.br: begin
              pc_src   = PC_SRC_D;
              pc_load  = 1'b1;
              flush_fd = 1'b1;
            end
            act.hold: ;
            act.intr: state_d = ST_INT_PUSH;
            act.inc:  pc_inc  = 1'b1;
            default:  ;
          endcase
        end
        ST_INT_PUSH: begin
          push_pc  = 1'b1;
          flush_fd = 1'b1;
          flush_de = 1'b1;
          state_d  = ST_INT_RD;
        end
        ST_INT_RD: begin
          vec_rd   = 1'b1;
          vec_addr = INT_VEC_ADDR;
          flush_fd = 1'b1;
          state_d  = ST_INT_LD;
        end
        ST_INT_LD: begin
          vec_rd   = 1'b1;
          vec_addr = INT_VEC_ADDR;
          pc_src   = PC_SRC_VEC;
          pc_load  = 1'b1;
          int_ack  = 1'b1;
          isr_set  = 1'b1;
          state_d  = ST_RUN;
        end
        default: state_d = ST_RST_RD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RST_RD;
      in_isr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (isr_clr)
        in_isr_q <= 1'b0;
      else if (isr_set)
        in_isr_q <= 1'b1;
    end
  end

  // forced low during reset so every output reads 0 that cycle
  assign in_isr = in_isr_q & ~rst;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: one packed compare of all
// outputs per cycle against hand-computed vectors.
module tb_pc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       intr;
  logic       br_taken_d;
  logic       jmp_ex;
  logic       ret_mem;
  logic       rti_mem;
  logic       hazard_stall;
  logic [1:0] pc_src;
  logic       pc_load;
  logic       pc_inc;
  logic       vec_rd;
  logic [7:0] vec_addr;
  logic       flush_fd;
  logic       flush_de;
  logic       flush_em;
  logic       push_pc;
  logic       int_ack;
  logic       in_isr;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] INT  = 6'b100000;
  localparam logic [5:0] BR   = 6'b010000;
  localparam logic [5:0] JMP  = 6'b001000;
  localparam logic [5:0] RET  = 6'b000100;
  localparam logic [5:0] RTI  = 6'b000010;
  localparam logic [5:0] STL  = 6'b000001;

  always #5 clk = ~clk;

  pc_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .intr         (intr),
    .br_taken_d   (br_taken_d),
    .jmp_ex       (jmp_ex),
    .ret_mem      (ret_mem),
    .rti_mem      (rti_mem),
    .hazard_stall (hazard_stall),
    .pc_src       (pc_src),
    .pc_load      (pc_load),
    .pc_inc       (pc_inc),
    .vec_rd       (vec_rd),
    .vec_addr     (vec_addr),
    .flush_fd     (flush_fd),
    .flush_de     (flush_de),
    .flush_em     (flush_em),
    .push_pc      (push_pc),
    .int_ack      (int_ack),
    .in_isr       (in_isr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // drive one cycle at negedge, compare Mealy outputs 1ns later
  task automatic cyc(input string      tag,
                     input logic       r,
                     input logic [5:0] in,
                     input logic [1:0] src,
                     input logic       ld,
                     input logic       inc,
                     input logic       vrd,
                     input logic [7:0] va,
                     input logic [2:0] fl,
                     input logic       push,
                     input logic       ack,
                     input logic       isr);
    logic [31:0] got;
    logic [31:0] exp;
    @(negedge clk);
    rst          = r;
    intr         = in[5];
    br_taken_d   = in[4];
    jmp_ex       = in[3];
    ret_mem      = in[2];
    rti_mem      = in[1];
    hazard_stall = in[0];
    #1;
    got = {13'd0, pc_src, pc_load, pc_inc, vec_rd, vec_addr,
           flush_fd, flush_de, flush_em, push_pc, int_ack,
           in_isr};
    exp = {13'd0, src, ld, inc, vrd, va, fl, push, ack, isr};
    chk(tag, got, exp);
  endtask

  initial begin
    rst = 1'b1;
    {intr, br_taken_d, jmp_ex} = '0;
    {ret_mem, rti_mem, hazard_stall} = '0;
    // tag       rst in        src   ld inc vrd va   fl   pu ak is
    cyc("rst0",  1, NONE,      2'b00, 0, 0, 0, 8'd0, 3'b000, 0, 0, 0);
    cyc("rst1",  1, NONE,      2'b00, 0, 0, 0, 8'd0, 3'b000, 0, 0, 0);
    cyc("rv_rd", 0, NONE,      2'b00, 0, 0, 1, 8'd0, 3'b000, 0, 0, 0);
    cyc("rv_ld", 0, JMP|INT,   2'b01, 1, 0, 1, 8'd0, 3'b000, 0, 0, 0);
    cyc("inc0",  0, NONE,      2'b00, 0, 1, 0, 8'd0, 3'b000, 0, 0, 0);
    cyc("inc1",  0, NONE,      2'b00, 0, 1, 0, 8'd0, 3'b000, 0, 0, 0);
    cyc("br_jmp",0, BR|JMP,    2'b00, 1, 0, 0, 8'd0, 3'b110, 0, 0, 0);
    cyc("inc2",  0, NONE,      2'b00, 0, 1, 0, 8'd0, 3'b000, 0, 0, 0);
    cyc("br_stl",0, BR|STL,    2'b00, 0, 0, 0, 8'd0, 3'b000, 0, 0, 0);
    cyc("br_rs", 0, BR,        2'b10, 1, 0, 0, 8'd0, 3'b100, 0, 0, 0);
    cyc("jmpstl",0, JMP|STL,   2'b00, 1, 0, 0, 8'd0, 3'b110, 0, 0, 0);
    cyc("ret_pr",0, RET|JMP|BR,2'b11, 1, 0, 0, 8'd0, 3'b111, 0, 0, 0);
    cyc("int_rq",0, INT,       2'b00, 0, 0, 0, 8'd0, 3'b000, 0, 0, 0);
    cyc("i_push",0, INT|JMP,   2'b00, 0, 0, 0, 8'd0, 3'b110, 1, 0, 0);
    cyc("i_rd",  0, RET,       2'b00, 0, 0, 1, 8'd1, 3'b100, 0, 0, 0);
    cyc("i_ld",  0, NONE,      2'b01, 1, 0, 1, 8'd1, 3'b000, 0, 1, 0);
    cyc("nest0", 0, INT,       2'b00, 0, 1, 0, 8'd0, 3'b000, 0, 0, 1);
    cyc("nest1", 0, INT,       2'b00, 0, 1, 0, 8'd0, 3'b000, 0, 0, 1);
    cyc("rti",   0, RET|RTI|INT,2'b11,1, 0, 0, 8'd0, 3'b111, 0, 0, 1);
    cyc("reint", 0, INT,       2'b00, 0, 0, 0, 8'd0, 3'b000, 0, 0, 0);
    cyc("push2", 0, NONE,      2'b00, 0, 0, 0, 8'd0, 3'b110, 1, 0, 0);
    cyc("rst_ir",1, INT,       2'b00, 0, 0, 0, 8'd0, 3'b000, 0, 0, 0);
    cyc("rv_rd2",0, NONE,      2'b00, 0, 0, 1, 8'd0, 3'b000, 0, 0, 0);
    cyc("rv_ld2",0, NONE,      2'b01, 1, 0, 1, 8'd0, 3'b000, 0, 0, 0);
    cyc("inc3",  0, NONE,      2'b00, 0, 1, 0, 8'd0, 3'b000, 0, 0, 0);
    cyc("ret_in",0, RET|INT,   2'b11, 1, 0, 0, 8'd0, 3'b111, 0, 0, 0);
    cyc("t6_rq", 0, INT,       2'b00, 0, 0, 0, 8'd0, 3'b000, 0, 0, 0);
    cyc("t6_psh",0, NONE,      2'b00, 0, 0, 0, 8'd0, 3'b110, 1, 0, 0);
    cyc("t6_rd", 0, NONE,      2'b00, 0, 0, 1, 8'd1, 3'b100, 0, 0, 0);
    cyc("t6_ld", 0, NONE,      2'b01, 1, 0, 1, 8'd1, 3'b000, 0, 1, 0);
    cyc("t6_isr",0, NONE,      2'b00, 0, 1, 0, 8'd0, 3'b000, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
